// File: rtl/csr_wr_sched.sv
// csr_wr_sched
//   Owns the single CSR-file write port. In IDLE it forwards the writeback
//   CSR write. On a trap request it replays the trap-entry sequence:
//   mepc, mcause, optional mtval, then mstatus. On an MRET request it writes
//   mstatus once. The pipeline is held (stall_o) while a sequence is active.
//
// Parameters
//   XLEN      : CSR data width
//   HAS_MTVAL : 1 includes the mtval write step, 0 skips it
//
// Ports
//   clk_i, rst_n_i             : clock (rising edge), async active-low reset
//   wb_csr_we_i/waddr_i/wdata_i : writeback-stage CSR write request
//   trap_req_i                  : one-cycle trap-entry request
//   trap_mepc_i/mcause_i/mtval_i: trap operands, sampled with trap_req_i
//   mret_req_i                  : one-cycle MRET request
//   mstatus_i                   : current mstatus from the CSR file
//   csr_we_o/waddr_o/wdata_o    : registered CSR-file write port
//   stall_o                     : pipeline hold, high whenever not IDLE
//   trap_done_o / mret_done_o   : one-cycle pulses with the final mstatus write
module csr_wr_sched #(
  parameter int XLEN      = 32,
  parameter bit HAS_MTVAL = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wb_csr_we_i,
  input  logic [11:0]     wb_csr_waddr_i,
  input  logic [XLEN-1:0] wb_csr_wdata_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_mepc_i,
  input  logic [XLEN-1:0] trap_mcause_i,
  input  logic [XLEN-1:0] trap_mtval_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            stall_o,
  output logic            trap_done_o,
  output logic            mret_done_o
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    W_MSTATUS,
    M_MSTATUS
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode.
  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m_in);
    logic [XLEN-1:0] m;
    m        = m_in;
    m[7]     = m_in[3];
    m[3]     = 1'b0;
    m[12:11] = 2'b11;
    return m;
  endfunction

  // MRET: MIE <= MPIE, MPIE <= 1.
  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m_in);
    logic [XLEN-1:0] m;
    m    = m_in;
    m[3] = m_in[7];
    m[7] = 1'b1;
    return m;
  endfunction

  assign stall_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      mepc_q      <= '0;
      mcause_q    <= '0;
      mtval_q     <= '0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= 12'h000;
      csr_wdata_o <= '0;
      trap_done_o <= 1'b0;
      mret_done_o <= 1'b0;
    end else begin
      // Every cycle defaults to an idle write port; states override below.
      csr_we_o    <= 1'b0;
      csr_waddr_o <= 12'h000;
      csr_wdata_o <= '0;
      trap_done_o <= 1'b0;
      mret_done_o <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // The writeback write belongs to an older instruction, so it is
          // committed even in the cycle a trap is accepted.
          if (wb_csr_we_i) begin
            csr_we_o    <= 1'b1;
            csr_waddr_o <= wb_csr_waddr_i;
            csr_wdata_o <= wb_csr_wdata_i;
          end
          if (trap_req_i) begin
            mepc_q   <= trap_mepc_i;
            mcause_q <= trap_mcause_i;
            mtval_q  <= trap_mtval_i;
            state_q  <= W_MEPC;
          end else if (mret_req_i) begin
            state_q  <= M_MSTATUS;
          end
        end

        W_MEPC: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MEPC;
          csr_wdata_o <= mepc_q;
          state_q     <= W_MCAUSE;
        end

        W_MCAUSE: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MCAUSE;
          csr_wdata_o <= mcause_q;
          state_q     <= HAS_MTVAL ? W_MTVAL : W_MSTATUS;
        end

        W_MTVAL: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MTVAL;
          csr_wdata_o <= mtval_q;
          state_q     <= W_MSTATUS;
        end

        // mstatus_i is read here, late enough that a writeback write issued
        // alongside the trap request has already landed in the CSR file.
        W_MSTATUS: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MSTATUS;
          csr_wdata_o <= trap_mstatus(mstatus_i);
          trap_done_o <= 1'b1;
          state_q     <= IDLE;
        end

        M_MSTATUS: begin
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_MSTATUS;
          csr_wdata_o <= mret_mstatus(mstatus_i);
          mret_done_o <= 1'b1;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_wr_sched.sv
`timescale 1ns/1ps
module tb_csr_wr_sched;

  localparam int XLEN = 32;

  typedef struct {
    int              cyc;
    logic [11:0]     addr;
    logic [XLEN-1:0] data;
    logic            td;
    logic            md;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic            wb_csr_we_i;
  logic [11:0]     wb_csr_waddr_i;
  logic [XLEN-1:0] wb_csr_wdata_i;
  logic            trap_req_i;
  logic [XLEN-1:0] trap_mepc_i;
  logic [XLEN-1:0] trap_mcause_i;
  logic [XLEN-1:0] trap_mtval_i;
  logic            mret_req_i;

  // DUT a: HAS_MTVAL=1, DUT b: HAS_MTVAL=0. Each has its own mstatus model.
  logic            a_we, b_we, a_stall, b_stall, a_td, b_td, a_md, b_md;
  logic [11:0]     a_addr, b_addr;
  logic [XLEN-1:0] a_data, b_data;
  logic [XLEN-1:0] ms_a, ms_b;

  logic            ms_load;
  logic [XLEN-1:0] ms_val;

  exp_t q_a[$];
  exp_t q_b[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  csr_wr_sched #(.XLEN(XLEN), .HAS_MTVAL(1'b1)) dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_csr_we_i(wb_csr_we_i), .wb_csr_waddr_i(wb_csr_waddr_i), .wb_csr_wdata_i(wb_csr_wdata_i),
    .trap_req_i(trap_req_i), .trap_mepc_i(trap_mepc_i), .trap_mcause_i(trap_mcause_i),
    .trap_mtval_i(trap_mtval_i), .mret_req_i(mret_req_i), .mstatus_i(ms_a),
    .csr_we_o(a_we), .csr_waddr_o(a_addr), .csr_wdata_o(a_data),
    .stall_o(a_stall), .trap_done_o(a_td), .mret_done_o(a_md)
  );

  csr_wr_sched #(.XLEN(XLEN), .HAS_MTVAL(1'b0)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wb_csr_we_i(wb_csr_we_i), .wb_csr_waddr_i(wb_csr_waddr_i), .wb_csr_wdata_i(wb_csr_wdata_i),
    .trap_req_i(trap_req_i), .trap_mepc_i(trap_mepc_i), .trap_mcause_i(trap_mcause_i),
    .trap_mtval_i(trap_mtval_i), .mret_req_i(mret_req_i), .mstatus_i(ms_b),
    .csr_we_o(b_we), .csr_waddr_o(b_addr), .csr_wdata_o(b_data),
    .stall_o(b_stall), .trap_done_o(b_td), .mret_done_o(b_md)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Minimal CSR-file model for mstatus, so mstatus_i follows committed writes.
  always @(posedge clk_i) begin
    if (ms_load) ms_a <= ms_val;
    else if (a_we && a_addr == 12'h300) ms_a <= a_data;
    if (ms_load) ms_b <= ms_val;
    else if (b_we && b_addr == 12'h300) ms_b <= b_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit dut_b_sel, input int c, input logic [11:0] addr,
                      input logic [XLEN-1:0] data, input logic td, input logic md);
    exp_t e;
    e.cyc = c; e.addr = addr; e.data = data; e.td = td; e.md = md;
    if (dut_b_sel) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_outputs"}, {a_we, a_addr, a_data, a_stall, a_td, a_md}, 64'd0);
    chk({tag, "_b_outputs"}, {b_we, b_addr, b_data, b_stall, b_td, b_md}, 64'd0);
  endtask

  task automatic trap_pulse(input logic [XLEN-1:0] mepc, input logic [XLEN-1:0] mcause,
                            input logic [XLEN-1:0] mtval, input logic also_mret);
    trap_req_i    = 1'b1;
    trap_mepc_i   = mepc;
    trap_mcause_i = mcause;
    trap_mtval_i  = mtval;
    mret_req_i    = also_mret;
  endtask

  task automatic clear_inputs();
    wb_csr_we_i = 1'b0; wb_csr_waddr_i = '0; wb_csr_wdata_i = '0;
    trap_req_i = 1'b0; trap_mepc_i = '0; trap_mcause_i = '0; trap_mtval_i = '0;
    mret_req_i = 1'b0;
  endtask

  task automatic load_mstatus(input logic [XLEN-1:0] v);
    ms_load = 1'b1; ms_val = v;
    step(1);
    ms_load = 1'b0;
    step(1);
  endtask

  // Pushes the expected trap-entry writes for both builds.
  task automatic expect_trap(input int n, input logic [XLEN-1:0] mepc, input logic [XLEN-1:0] mcause,
                             input logic [XLEN-1:0] mtval, input logic [XLEN-1:0] mst);
    push(0, n+2, 12'h341, mepc,   1'b0, 1'b0);
    push(0, n+3, 12'h342, mcause, 1'b0, 1'b0);
    push(0, n+4, 12'h343, mtval,  1'b0, 1'b0);
    push(0, n+5, 12'h300, mst,    1'b1, 1'b0);
    push(1, n+2, 12'h341, mepc,   1'b0, 1'b0);
    push(1, n+3, 12'h342, mcause, 1'b0, 1'b0);
    push(1, n+4, 12'h300, mst,    1'b1, 1'b0);
  endtask

  // Scoreboard monitors: pop an expectation whenever a DUT drives its port.
  always @(negedge clk_i) begin
    exp_t e;
    if (a_we || a_td || a_md) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_output", {a_we, a_addr, a_data, a_td, a_md}, 64'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_write_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_write", {a_we, a_addr, a_data, a_td, a_md}, {1'b1, e.addr, e.data, e.td, e.md});
      end
    end else begin
      chk("a_idle_port_zero", {a_addr, a_data}, 64'd0);
    end
  end

  always @(negedge clk_i) begin
    exp_t e;
    if (b_we || b_td || b_md) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_output", {b_we, b_addr, b_data, b_td, b_md}, 64'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_write_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_write", {b_we, b_addr, b_data, b_td, b_md}, {1'b1, e.addr, e.data, e.td, e.md});
      end
    end else begin
      chk("b_idle_port_zero", {b_addr, b_data}, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_inputs();
    ms_load = 1'b0;
    ms_val  = '0;
    rst_n_i = 1'b0;
    #2;
    chk_all_zero("reset_async");
    step(2);
    chk_all_zero("reset_held");
    rst_n_i = 1'b1;
    step(3);
    chk_all_zero("idle_after_reset");

    // Plain writeback forwarding.
    n = cyc;
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h305; wb_csr_wdata_i = 32'h0000_0100;
    push(0, n+1, 12'h305, 32'h0000_0100, 1'b0, 1'b0);
    push(1, n+1, 12'h305, 32'h0000_0100, 1'b0, 1'b0);
    step(1);
    clear_inputs();
    step(3);

    // Basic trap entry; stray wb write and MRET while busy must be ignored.
    load_mstatus(32'h0000_0008);
    n = cyc;
    trap_pulse(32'h8000_0010, 32'h8000_000B, 32'h0, 1'b0);
    expect_trap(n, 32'h8000_0010, 32'h8000_000B, 32'h0, 32'h0000_1880);
    chk("trap_stall_n", {a_stall, b_stall}, 64'd0);
    step(1);
    clear_inputs();
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h7C0; wb_csr_wdata_i = 32'h0000_0BAD;
    chk("trap_stall_n1", {a_stall, b_stall}, 64'b11);
    step(1);
    clear_inputs();
    mret_req_i = 1'b1;
    chk("trap_stall_n2", {a_stall, b_stall}, 64'b11);
    step(1);
    clear_inputs();
    chk("trap_stall_n3", {a_stall, b_stall}, 64'b11);
    step(1);
    chk("trap_stall_n4", {a_stall, b_stall}, 64'b10);
    step(1);
    chk("trap_stall_n5", {a_stall, b_stall}, 64'b00);
    step(3);

    // Writeback csrw mstatus in the same cycle as the trap request.
    load_mstatus(32'h0);
    n = cyc;
    wb_csr_we_i = 1'b1; wb_csr_waddr_i = 12'h300; wb_csr_wdata_i = 32'h0000_0008;
    trap_pulse(32'h0000_0100, 32'h0000_0002, 32'h0000_DEAD, 1'b0);
    push(0, n+1, 12'h300, 32'h0000_0008, 1'b0, 1'b0);
    push(1, n+1, 12'h300, 32'h0000_0008, 1'b0, 1'b0);
    expect_trap(n, 32'h0000_0100, 32'h0000_0002, 32'h0000_DEAD, 32'h0000_1880);
    step(1);
    clear_inputs();
    step(7);

    // MRET from the mstatus just written by the trap (0x1880).
    n = cyc;
    mret_req_i = 1'b1;
    push(0, n+2, 12'h300, 32'h0000_1888, 1'b0, 1'b1);
    push(1, n+2, 12'h300, 32'h0000_1888, 1'b0, 1'b1);
    step(1);
    clear_inputs();
    chk("mret_stall_n1", {a_stall, b_stall}, 64'b11);
    step(4);

    // Trap and MRET together: trap wins, mstatus 0x1888 -> 0x1880.
    n = cyc;
    trap_pulse(32'h0000_0200, 32'h0000_0007, 32'h0000_0055, 1'b1);
    expect_trap(n, 32'h0000_0200, 32'h0000_0007, 32'h0000_0055, 32'h0000_1880);
    step(1);
    clear_inputs();
    step(7);

    // Bit-boundary patterns: trap from MIE=0/MPP=0, then MRET with MPIE=0.
    load_mstatus(32'hFFFF_E7F7);
    n = cyc;
    trap_pulse(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    expect_trap(n, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FF77);
    step(1);
    clear_inputs();
    step(7);
    n = cyc;
    mret_req_i = 1'b1;
    push(0, n+2, 12'h300, 32'hFFFF_FFF7, 1'b0, 1'b1);
    push(1, n+2, 12'h300, 32'hFFFF_FFF7, 1'b0, 1'b1);
    step(1);
    clear_inputs();
    step(4);

    // Reset while in W_MCAUSE aborts the sequence.
    trap_pulse(32'h0000_0300, 32'h0000_0400, 32'h0000_0500, 1'b0);
    step(1);
    clear_inputs();
    step(1);
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("reset_mid_seq");
    step(2);
    rst_n_i = 1'b1;
    step(10);
    chk("post_reset_stall", {a_stall, b_stall, a_td, b_td, a_md, b_md}, 64'd0);

    chk("a_queue_drained", 64'(q_a.size()), 64'd0);
    chk("b_queue_drained", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
